bin2bcd_serial: RTL and testbench
=================================

# bin2bcd_serial

Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment display driver. It turns a 14-bit binary value (from switches, counters or core registers) into four packed BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock. Values above 9999 saturate to 9999 and raise an overflow flag. It replaces a wide combinational divider with a small FSM that closes timing easily at 100 MHz.

## Interface
- BIN_WIDTH, 14, width of binary input; also the number of shift cycles.
- DIGITS, 4, number of BCD digits presented on bcd_o.
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request conversion of bin_i; sampled only in IDLE or DONE.
- bin_i  input  BIN_WIDTH  binary value, captured on the accepting edge only.
- busy_o  output  1  high while a conversion is in progress (state SHIFT).
- done_o  output  1  one-cycle pulse; bcd_o and overflow_o are valid and updated this cycle.
- bcd_o  output  4*DIGITS  packed BCD, [15:12] thousands down to [3:0] units; held between conversions.
- overflow_o  output  1  last result exceeded 10^DIGITS-1; held with bcd_o.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: start_i=1 -> load shift register {scratch=0, bin=bin_i}, clear bit counter, go to SHIFT.
- SHIFT: each cycle, every BCD nibble of scratch (DIGITS+1 nibbles, 20 bits) >= 5 gets +3, then the whole {scratch, bin} register shifts left by 1. Counter increments; after the BIN_WIDTH-th shift, go to DONE.
- DONE, on entry edge: if the top (ten-thousands) nibble != 0, bcd_o <= 16'h9999 and overflow_o <= 1. Otherwise bcd_o <= low 16 bits of scratch and overflow_o <= 0. done_o is high for exactly this one cycle.
- DONE: start_i=1 -> start a new conversion directly, giving back-to-back throughput. Otherwise go to IDLE.
- start_i in SHIFT is ignored and not queued. bin_i changes after acceptance have no effect.
- Add-3 is applied before the shift, never after the final shift.
- Reset (any time, including mid-SHIFT): state IDLE, counter 0, shift register 0, bcd_o=0, overflow_o=0, busy_o=0, done_o=0. A partial result is never published.

## Timing
- Start accepted at edge E0, with start_i high in cycle 0.
- Cycles 1..BIN_WIDTH (1..14): busy_o=1.
- Cycle BIN_WIDTH+1 (15): done_o=1, busy_o=0, new bcd_o/overflow_o visible.
- Latency is fixed at BIN_WIDTH+1 cycles from the start cycle to done, independent of value.
- Back-to-back: with start_i held high continuously, done_o pulses every BIN_WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- The shared display package holds:
  - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - BCD_MAX=16'h9999;
  - DISP_DIGITS=4, so the display driver and this block agree on digit count.
- Sub-module bcd_digit_adjust: combinational, one nibble in, one nibble out (+3 when >=5). It is instantiated DIGITS+1 times in a generate loop.
- The counter width is $clog2(BIN_WIDTH+1).

## Test plan
- Reset, then bin_i=0, pulse start_i -> done_o at cycle 15, bcd_o=16'h0000, overflow_o=0.
- bin_i=1234, start -> busy_o high in cycles 1..14, done_o in cycle 15 only, bcd_o=16'h1234.
- bin_i=9999 -> bcd_o=16'h9999, overflow_o=0. Then bin_i=10000 -> bcd_o=16'h9999, overflow_o=1. Then bin_i=16383 -> same saturation, overflow_o=1.
- Start with bin_i=42, pulse start_i again at cycle 5 with bin_i=777 -> single done at cycle 15 with bcd_o=16'h0042; second start ignored.
- start_i held high, bin_i=5 then 60 -> done pulses at cycles 15 and 30, bcd_o=16'h0005 then 16'h0060.
- Convert 1234, start 5678, then assert rst_i low at cycle 8 -> all outputs 0 immediately (asynchronous); no done_o; after release, 5678 converts correctly in 15 cycles.

Source files
------------

// File: rtl/bin2bcd_serial_pkg.sv
// Shared display definitions: FSM encoding, saturation value and the digit
// count that the seven-segment driver and this converter both rely on.
package bin2bcd_serial_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [15:0] BCD_MAX     = 16'h9999;
    localparam int          DISP_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/bin2bcd_serial_if.sv
// Request/result bundle between a value source and the BCD converter.
interface bin2bcd_serial_if #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
);
    logic                  start_i;
    logic [BIN_WIDTH-1:0]  bin_i;
    logic                  busy_o;
    logic                  done_o;
    logic [4*DIGITS-1:0]   bcd_o;
    logic                  overflow_o;

    modport master (
        output start_i, bin_i,
        input  busy_o, done_o, bcd_o, overflow_o
    );

    modport slave (
        input  start_i, bin_i,
        output busy_o, done_o, bcd_o, overflow_o
    );
endinterface

// File: rtl/bin2bcd_serial_digit_adjust.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
    input  logic [3:0] nibble_in,
    output logic [3:0] nibble_out
);
    assign nibble_out = (nibble_in >= 4'd5) ? (nibble_in + 4'd3) : nibble_in;
endmodule

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Results above the displayable range saturate to all nines with overflow set.
module bin2bcd_serial
    import bin2bcd_serial_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = DISP_DIGITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    bin2bcd_serial_if.slave  bus
);
    // One spare nibble above the displayed digits catches the overflow digit.
    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int SR_W  = SCR_W + BIN_WIDTH;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);
    localparam logic [BCD_W-1:0] SAT_VAL  = {DIGITS{4'h9}};

    state_t             state_reg, state_next;
    logic [SR_W-1:0]    sr_reg, sr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic               overflow_reg, overflow_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SR_W-1:0]    sr_shifted;

    // Correct every scratch nibble in parallel before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .nibble_in  (sr_reg[BIN_WIDTH + 4*gi +: 4]),
                .nibble_out (scratch_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign sr_shifted = {scratch_adj, sr_reg[BIN_WIDTH-1:0]} << 1;

    // State and datapath registers; reset discards any partial conversion.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            sr_reg       <= '0;
            cnt_reg      <= '0;
            bcd_reg      <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sr_reg       <= sr_next;
            cnt_reg      <= cnt_next;
            bcd_reg      <= bcd_next;
            overflow_reg <= overflow_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Next-state and datapath logic; results publish on the edge of the last shift.
    always_comb begin
        state_next    = state_reg;
        sr_next       = sr_reg;
        cnt_next      = cnt_reg;
        bcd_next      = bcd_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    sr_next    = {{SCR_W{1'b0}}, bus.bin_i};
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sr_next  = sr_shifted;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_CNT) begin
                    state_next = ST_DONE;
                    if (sr_shifted[SR_W-1 -: 4] != 4'd0) begin
                        bcd_next      = SAT_VAL;
                        overflow_next = 1'b1;
                    end else begin
                        bcd_next      = sr_shifted[BIN_WIDTH +: BCD_W];
                        overflow_next = 1'b0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Status flags are registered copies of the state being entered.
        busy_next = (state_next == ST_SHIFT);
        done_next = (state_next == ST_DONE);
    end

    assign bus.busy_o     = busy_reg;
    assign bus.done_o     = done_reg;
    assign bus.bcd_o      = bcd_reg;
    assign bus.overflow_o = overflow_reg;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: vector table, corner sequences and
// randomized values against an arithmetic reference model.
module tb_bin2bcd_serial;
    import bin2bcd_serial_pkg::*;

    localparam int BW = 14;
    localparam int DG = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    bin2bcd_serial_if #(.BIN_WIDTH(BW), .DIGITS(DG)) bus_if ();

    bin2bcd_serial #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Decimal digits by plain division; saturate above 9999.
    function automatic logic [16:0] ref_conv(input int v);
        if (v > 9999) return {1'b1, BCD_MAX};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One conversion from an idle DUT; checks busy window and single done pulse.
    task automatic run_conv(input int v, input string tag, output logic [15:0] bcd, output logic ovf);
        int bad;
        bad = 0;
        bus_if.start_i = 1'b1;
        bus_if.bin_i   = BW'(v);
        tick();
        bus_if.start_i = 1'b0;
        bus_if.bin_i   = BW'($urandom);
        for (int c = 1; c <= BW; c++) begin
            if (bus_if.busy_o !== 1'b1 || bus_if.done_o !== 1'b0) bad++;
            tick();
        end
        check({tag, "_busy_window"}, 32'(bad), 32'd0);
        check({tag, "_done_pulse"}, 32'(bus_if.done_o), 32'd1);
        check({tag, "_busy_at_done"}, 32'(bus_if.busy_o), 32'd0);
        bcd = bus_if.bcd_o;
        ovf = bus_if.overflow_o;
        $display("conv %s bin=%0d bcd=%h ovf=%b", tag, v, bcd, ovf);
        tick();
        check({tag, "_done_one_cycle"}, 32'(bus_if.done_o), 32'd0);
    endtask

    initial begin
        logic [15:0] bcd;
        logic        ovf;
        logic [16:0] exp;
        int          bad;
        int          v;

        vecs[0]  = '{0,     16'h0000, 1'b0};
        vecs[1]  = '{1234,  16'h1234, 1'b0};
        vecs[2]  = '{9999,  16'h9999, 1'b0};
        vecs[3]  = '{10000, 16'h9999, 1'b1};
        vecs[4]  = '{16383, 16'h9999, 1'b1};
        vecs[5]  = '{5,     16'h0005, 1'b0};
        vecs[6]  = '{60,    16'h0060, 1'b0};
        vecs[7]  = '{1000,  16'h1000, 1'b0};
        vecs[8]  = '{8191,  16'h8191, 1'b0};
        vecs[9]  = '{99,    16'h0099, 1'b0};
        vecs[10] = '{4095,  16'h4095, 1'b0};
        vecs[11] = '{777,   16'h0777, 1'b0};

        bus_if.start_i = 1'b0;
        bus_if.bin_i   = '0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(bus_if.busy_o), 32'd0);
        check("rst_done", 32'(bus_if.done_o), 32'd0);
        check("rst_bcd", 32'(bus_if.bcd_o), 32'd0);
        check("rst_ovf", 32'(bus_if.overflow_o), 32'd0);
        rst_i = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].bin, $sformatf("vec%0d", i), bcd, ovf);
            check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
        end

        // Start during SHIFT is ignored and not queued
        bus_if.start_i = 1'b1;
        bus_if.bin_i   = BW'(42);
        tick();
        bus_if.start_i = 1'b0;
        bus_if.bin_i   = '0;
        repeat (4) tick();
        bus_if.start_i = 1'b1;
        bus_if.bin_i   = BW'(777);
        tick();
        bus_if.start_i = 1'b0;
        repeat (9) tick();
        check("ign_done", 32'(bus_if.done_o), 32'd1);
        check("ign_bcd", 32'(bus_if.bcd_o), 32'h0042);
        $display("seq ignore_start bcd=%h", bus_if.bcd_o);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_if.done_o !== 1'b0 || bus_if.busy_o !== 1'b0) bad++;
        end
        check("ign_no_second", 32'(bad), 32'd0);

        // Back-to-back with start held high
        bus_if.start_i = 1'b1;
        bus_if.bin_i   = BW'(5);
        tick();
        bus_if.bin_i   = BW'(60);
        bad = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 15) begin
                check("b2b_done1", 32'(bus_if.done_o), 32'd1);
                check("b2b_bcd1", 32'(bus_if.bcd_o), 32'h0005);
            end else if (c == 30) begin
                check("b2b_done2", 32'(bus_if.done_o), 32'd1);
                check("b2b_bcd2", 32'(bus_if.bcd_o), 32'h0060);
            end else if (bus_if.done_o !== 1'b0) begin
                bad++;
            end
            if (c == 30) bus_if.start_i = 1'b0;
            tick();
        end
        check("b2b_stray_done", 32'(bad), 32'd0);
        check("b2b_idle_after", 32'({bus_if.done_o, bus_if.busy_o}), 32'd0);
        $display("seq back_to_back done");

        // Asynchronous reset mid-conversion
        run_conv(1234, "pre_rst", bcd, ovf);
        check("pre_rst_bcd", 32'(bcd), 32'h1234);
        bus_if.start_i = 1'b1;
        bus_if.bin_i   = BW'(5678);
        tick();
        bus_if.start_i = 1'b0;
        repeat (7) tick();
        rst_i = 1'b0;
        #1;
        check("arst_busy", 32'(bus_if.busy_o), 32'd0);
        check("arst_done", 32'(bus_if.done_o), 32'd0);
        check("arst_bcd", 32'(bus_if.bcd_o), 32'd0);
        check("arst_ovf", 32'(bus_if.overflow_o), 32'd0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus_if.done_o !== 1'b0 || bus_if.bcd_o !== 16'h0) bad++;
        end
        check("arst_hold", 32'(bad), 32'd0);
        rst_i = 1'b1;
        tick();
        run_conv(5678, "post_rst", bcd, ovf);
        check("post_rst_bcd", 32'(bcd), 32'h5678);
        check("post_rst_ovf", 32'(ovf), 32'd0);

        // Randomized values against the reference model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 16383);
            endcase
            exp = ref_conv(v);
            run_conv(v, $sformatf("rnd%0d", i), bcd, ovf);
            check($sformatf("rnd%0d_bcd", i), 32'(bcd), 32'(exp[15:0]));
            check($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(exp[16]));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
